// File: rtl/array_rw_ctrl.sv
// Request-side controller for a single-port, 1-cycle-latency, segment-masked SRAM.
// Arbitrates write/read channels onto the RW port and queues read data for the consumer.
module array_rw_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 1316,
  parameter int MASK_SEG   = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,

  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [MASK_SEG-1:0] wr_mask,
  input  logic [DATA_W-1:0]   wr_data,

  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [ADDR_W-1:0]   rd_addr,

  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,

  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [MASK_SEG-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int CRED_W = CNT_W + 1;
  localparam int PTR_W  = $clog2(RESP_DEPTH);

  logic                 wr_first;
  logic                 inflight;
  logic [CNT_W-1:0]     count;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [DATA_W-1:0]    q_mem [RESP_DEPTH];

  logic [CRED_W-1:0]    credit_used;
  logic                 rd_ok;
  logic                 grant_wr;
  logic                 grant_rd;
  logic                 push;
  logic                 pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RESP_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // A read reserves a queue slot at issue so its data can always be captured.
  always_comb begin
    credit_used = CRED_W'(count) + CRED_W'(inflight);
    rd_ok       = rd_valid && (credit_used < CRED_W'(RESP_DEPTH));
    grant_wr    = 1'b0;
    grant_rd    = 1'b0;
    if (!reset) begin
      grant_wr = wr_valid && (wr_first || !rd_ok);
      grant_rd = rd_ok && !grant_wr;
    end
  end

  assign wr_ready   = grant_wr;
  assign rd_ready   = grant_rd;

  assign mem_en     = grant_wr | grant_rd;
  assign mem_wmode  = grant_wr;
  assign mem_addr   = grant_rd ? rd_addr : wr_addr;
  assign mem_wmask  = grant_wr ? wr_mask : '0;
  assign mem_wdata  = wr_data;

  assign push       = inflight;
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = q_mem[head];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_first <= 1'b1;
      inflight <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      inflight <= grant_rd;
      if (wr_valid && rd_ok) wr_first <= !wr_first;
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Read data is only valid in the cycle after issue, so capture is unconditional on inflight.
  always_ff @(posedge clock) begin
    if (push) q_mem[tail] <= mem_rdata;
  end

endmodule

// File: tb/tb_array_rw_ctrl.sv
// Randomized self-checking bench for array_rw_ctrl with an SRAM model and a
// transaction-level reference (golden array plus outstanding-response queue).
module tb_array_rw_ctrl;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 1316;
  localparam int MASK_SEG   = 4;
  localparam int RESP_DEPTH = 2;
  localparam int SEG_W      = DATA_W / MASK_SEG;
  localparam int DEPTH      = 1 << ADDR_W;

  logic                clock = 1'b0;
  logic                reset;
  logic                wr_valid, wr_ready;
  logic [ADDR_W-1:0]   wr_addr;
  logic [MASK_SEG-1:0] wr_mask;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_valid, rd_ready;
  logic [ADDR_W-1:0]   rd_addr;
  logic                resp_valid, resp_ready;
  logic [DATA_W-1:0]   resp_data;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_en, mem_wmode;
  logic [MASK_SEG-1:0] mem_wmask;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;

  array_rw_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_SEG(MASK_SEG), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    int b;
    int lo;
    n_vec++;
    if (got !== exp) begin
      n_err++;
      b = 0;
      for (int i = DATA_W - 1; i >= 0; i--) if (got[i] !== exp[i]) b = i;
      lo = (b > DATA_W - 32) ? DATA_W - 32 : b;
      $display("FAIL %s @cyc %0d: first diff bit %0d, got[%0d+:32]=%h expected %h",
               tag, cyc, b, lo, got[lo +: 32], exp[lo +: 32]);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [42*32-1:0] t;
    for (int i = 0; i < 42; i++) t[i*32 +: 32] = $urandom();
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [MASK_SEG-1:0] m);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int s = 0; s < MASK_SEG; s++) if (m[s]) r[s*SEG_W +: SEG_W] = new_w[s*SEG_W +: SEG_W];
    return r;
  endfunction

  // SRAM macro model: 1-cycle read latency, garbage on mem_rdata when not valid.
  logic              sram_clr;
  logic [DATA_W-1:0] sram [DEPTH];
  logic [DATA_W-1:0] sram_q, junk;
  logic              sram_rv;

  always @(posedge clock) begin
    junk    <= rnd_data();
    sram_rv <= 1'b0;
    if (sram_clr) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
    end else if (mem_en) begin
      if (mem_wmode) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_wmask);
      else begin
        sram_q  <= sram[mem_addr];
        sram_rv <= 1'b1;
      end
    end
  end

  assign mem_rdata = sram_rv ? sram_q : junk;

  // Reference: golden array contents and the list of reads accepted but not yet consumed.
  typedef struct {
    logic [DATA_W-1:0] d;
    int                due;
  } resp_t;

  logic [DATA_W-1:0] golden [DEPTH];
  resp_t             exp_q[$];
  bit                m_wr_first;
  bit                e_rdok, e_wr, e_rd, e_rv;
  int                n_rd_obs = 0, n_wr_obs = 0, n_pop_obs = 0, en_cnt = 0;
  logic [5:0]        grant_log = '0;

  always @(negedge clock) begin
    if (reset) begin
      if (sram_clr) for (int i = 0; i < DEPTH; i++) golden[i] = '0;
      exp_q.delete();
      m_wr_first = 1'b1;
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_resp_valid", resp_valid, 0);
    end else begin
      e_rdok = rd_valid && (exp_q.size() < RESP_DEPTH);
      e_wr   = wr_valid && (m_wr_first || !e_rdok);
      e_rd   = e_rdok && !e_wr;
      e_rv   = (exp_q.size() > 0) && (exp_q[0].due <= cyc);

      chk("wr_ready", wr_ready, e_wr);
      chk("rd_ready", rd_ready, e_rd);
      chk("mem_en", mem_en, e_wr | e_rd);
      chk("mem_wmode", mem_wmode, e_wr);
      if (e_wr) begin
        chk("mem_addr_wr", mem_addr, wr_addr);
        chk("mem_wmask", mem_wmask, wr_mask);
        chk("mem_wdata", mem_wdata, wr_data);
      end
      if (e_rd) begin
        chk("mem_addr_rd", mem_addr, rd_addr);
        chk("mem_wmask_rd", mem_wmask, 0);
      end
      chk("resp_valid", resp_valid, e_rv);
      if (e_rv) chk("resp_data", resp_data, exp_q[0].d);

      n_rd_obs  += int'(rd_valid && rd_ready);
      n_wr_obs  += int'(wr_valid && wr_ready);
      n_pop_obs += int'(resp_valid && resp_ready);
      en_cnt    += int'(mem_en);
      grant_log  = {grant_log[4:0], wr_ready};

      if (wr_valid && e_rdok) m_wr_first = !m_wr_first;
      if (e_rv && resp_ready) void'(exp_q.pop_front());
      if (e_wr) golden[wr_addr] = merge(golden[wr_addr], wr_data, wr_mask);
      if (e_rd) exp_q.push_back('{d: golden[rd_addr], due: cyc + 2});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_accept(input bit is_rd, output int c);
    int  n;
    bit  hit;
    n   = 0;
    hit = 0;
    c   = -1;
    while (!hit && n < 50) begin
      @(negedge clock);
      n++;
      hit = is_rd ? (rd_valid && rd_ready) : (wr_valid && wr_ready);
      if (hit) c = cyc;
    end
    chk(is_rd ? "rd_accept_seen" : "wr_accept_seen", hit, 1);
    step(1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [MASK_SEG-1:0] m,
                          input logic [DATA_W-1:0] d);
    int c;
    wr_addr  = a;
    wr_mask  = m;
    wr_data  = d;
    wr_valid = 1'b1;
    wait_accept(1'b0, c);
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output int lat, output logic [DATA_W-1:0] d);
    int c;
    int n;
    rd_addr  = a;
    rd_valid = 1'b1;
    wait_accept(1'b1, c);
    rd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 20);
    chk("resp_seen", resp_valid, 1);
    lat = cyc - c;
    d   = resp_data;
    step(1);
  endtask

  logic [DATA_W-1:0] pat_a, got, exp_pm;
  int                lat, c, base, base2, wbase;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    sram_clr   = 1'b1;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_mask    = '0;
    wr_data    = '0;
    rd_valid   = 1'b0;
    rd_addr    = '0;
    resp_ready = 1'b0;
    step(3);
    sram_clr   = 1'b0;
    reset      = 1'b0;
    resp_ready = 1'b1;
    step(1);

    // write then read back, latency 2 edges
    pat_a = rnd_data();
    do_write(7'h05, 4'hF, pat_a);
    do_read(7'h05, lat, got);
    chk("wr_rd_latency", lat, 2);
    chk("wr_rd_data", got, pat_a);

    // partial mask on segment 1
    do_write(7'h10, 4'hF, '1);
    do_write(7'h10, 4'h2, '0);
    do_read(7'h10, lat, got);
    exp_pm = '1;
    exp_pm[657:329] = '0;
    chk("partial_mask", got, exp_pm);

    // conflict alternation from a fresh priority state
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    resp_ready = 1'b1;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    base = en_cnt;
    repeat (6) begin
      wr_addr = 7'($urandom_range(64, 127));
      wr_mask = 4'($urandom());
      wr_data = rnd_data();
      rd_addr = 7'($urandom_range(64, 127));
      step(1);
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    chk("alt_grants", grant_log, 6'b101010);
    chk("alt_mem_en", en_cnt - base, 6);
    step(4);

    // backpressure: queue fills, writes still flow, one pop frees exactly one slot
    resp_ready = 1'b0;
    rd_valid   = 1'b1;
    rd_addr    = 7'h05;
    base = n_rd_obs;
    step(4);
    chk("bp_reads_accepted", n_rd_obs - base, 2);
    wr_valid = 1'b1;
    wr_addr  = 7'h60;
    wr_mask  = 4'hF;
    wr_data  = rnd_data();
    wbase = n_wr_obs;
    step(2);
    chk("bp_writes_flow", n_wr_obs - wbase, 2);
    chk("bp_reads_blocked", n_rd_obs - base, 2);
    wr_valid   = 1'b0;
    resp_ready = 1'b1;
    step(1);
    resp_ready = 1'b0;
    base2 = n_rd_obs;
    step(4);
    chk("bp_one_more_read", n_rd_obs - base2, 1);
    rd_valid   = 1'b0;
    resp_ready = 1'b1;
    step(6);

    // streamed reads, responses checked in order by the reference
    base = n_pop_obs;
    for (int a = 0; a < 8; a++) begin
      rd_addr  = 7'(a);
      rd_valid = 1'b1;
      wait_accept(1'b1, c);
    end
    rd_valid = 1'b0;
    step(6);
    chk("stream_responses", n_pop_obs - base, 8);

    // reset in the cycle after a read issue
    rd_addr  = 7'h20;
    rd_valid = 1'b1;
    wait_accept(1'b1, c);
    rd_valid = 1'b0;
    reset    = 1'b1;
    base = n_pop_obs;
    step(2);
    reset = 1'b0;
    step(4);
    chk("stale_resp_count", n_pop_obs - base, 0);
    do_read(7'h05, lat, got);
    chk("post_reset_latency", lat, 2);
    chk("post_reset_data", got, pat_a);

    // random traffic
    repeat (800) begin
      wr_valid   = 1'($urandom_range(0, 1));
      wr_addr    = 7'($urandom_range(0, 15));
      wr_mask    = 4'($urandom());
      wr_data    = rnd_data();
      rd_valid   = 1'($urandom_range(0, 1));
      rd_addr    = 7'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    wr_valid   = 1'b0;
    rd_valid   = 1'b0;
    resp_ready = 1'b1;
    step(5);
    chk("final_resp_valid", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/array_rw_ctrl.md
Name: array_rw_ctrl

Overview:
- Request-side controller that drives one single-port, 1-cycle-read-latency, segment-masked SRAM macro (128 x 1316, 4 mask segments of 329 bits).
- Arbitrates independent write and read valid/ready request channels onto the one RW port.
- Captures read data in the cycle it becomes valid, into a 2-entry response queue with full backpressure.
- Sits directly upstream of the array macro and is its only client.

Parameters:
- ADDR_W, 7, array address width (depth 2^ADDR_W).
- DATA_W, 1316, array word width.
- MASK_SEG, 4, number of write-mask segments; DATA_W is divisible by MASK_SEG.
- RESP_DEPTH, 2, response queue entries; minimum 2.

Ports:
- clock  in  1  sole clock; also drives the array clock.
- reset  in  1  asynchronous, active-high.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_mask  in  MASK_SEG  per-segment write enable.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_W  read address.
- resp_valid  out  1  response queue head valid.
- resp_ready  in  1  consumer accepts the head.
- resp_data  out  DATA_W  response queue head data.
- mem_addr  out  ADDR_W  array address.
- mem_en  out  1  array enable.
- mem_wmode  out  1  1 = write, 0 = read.
- mem_wmask  out  MASK_SEG  array write mask.
- mem_wdata  out  DATA_W  array write data.
- mem_rdata  in  DATA_W  array read data; valid only in the cycle after a read issue, undefined otherwise.

Behaviour:
- Reset (async assert, released synchronously to clock):
  - resp_valid = 0; queue empty; in-flight flag = 0; priority flag = write-first.
  - mem_en = 0 while reset is asserted.
  - Reset mid-operation discards any in-flight read and all queued data.
- Issue rules (combinational from inputs and state):
  - rd_ok = rd_valid and (count + inflight < RESP_DEPTH).
  - With both wr_valid and rd_ok: grant the side selected by the priority flag, then toggle the flag to the other side.
  - With only one side eligible: grant it; the priority flag is unchanged.
  - wr_ready = write granted; rd_ready = read granted. The ready of an ungranted side is 0.
  - Either ready may depend combinationally on the other channel's valid.
- Array drive:
  - mem_en = wr_ready | rd_ready.
  - mem_wmode = wr_ready.
  - mem_addr = the granted address.
  - mem_wmask = wr_mask on a write, 0 on a read.
  - mem_wdata = wr_data on a write (don't-care otherwise; drive wr_data).
  - A write with wr_mask = 0 is still issued and consumes the port cycle.
- Read capture:
  - A read issued at edge N sets inflight for cycle N+1.
  - In cycle N+1, mem_rdata is written into the queue tail at edge N+1, unconditionally.
  - The credit check guarantees space, so capture never stalls.
  - Read-issue to resp_valid latency: 2 edges minimum.
- Response queue:
  - FIFO of RESP_DEPTH entries; head drives resp_data.
  - Pop on resp_valid & resp_ready.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
  - The count counts queue entries only; inflight is tracked separately.
  - Back-to-back reads sustain 1 per cycle while resp_ready = 1.
- Ordering:
  - Requests reach the array in grant order; responses return in read-issue order.
  - Read-after-write to the same address returns the new data when the write is granted first.
  - Within one cycle, only one request is granted, so the array never sees both operations.
- No address range checks (full 2^ADDR_W space is valid).

Test Plan:
- Write and read back: after reset, write addr 0x05, mask 0xF, data pattern A. Then read 0x05 with resp_ready = 1 → resp_valid exactly 2 edges after rd accept, resp_data = A.
- Partial mask: write 0x10 all-ones with mask 0xF, then write 0x10 all-zeros with mask 0x2, then read 0x10 → bits [657:329] = 0, all other bits = 1.
- Conflict alternation: hold wr_valid and rd_valid both = 1 for 6 cycles with resp_ready = 1 → grants go W,R,W,R,W,R and mem_en = 1 every cycle.
- Backpressure with resp_ready = 0: issue 4 reads →
  - only 2 are accepted and the queue fills with both;
  - rd_ready stays 0 and writes still proceed;
  - after one pop, exactly one more read is accepted.
- Simultaneous push/pop: stream reads to 0..7 with resp_ready = 1 → 8 responses, in address order, with no gaps after the first.
- Reset mid-operation: assert reset the cycle after a read issue → resp_valid = 0, queue empty, the stale response never appears, and the next read after reset returns correct data.
